// File: rtl/rx_latency_collector.sv
// rx_latency_collector
// Pulls a cycle stamp out of the first beat of each AXI-Stream packet and
// keeps running statistics on it: last, min, max, saturating sum and
// saturating count. The stream passes through a two-entry register slice
// that sustains one beat per clock.
//
// Optional build macro: RX_LATCOL_STAMP_STRIP_EN
//   defined   - the stamp field of every first beat is zeroed on the output
//   undefined - the stream is forwarded bit-exact, stamp included
module rx_latency_collector #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int STAMP_WIDTH     = 48,
    parameter int COUNT_WIDTH     = 32,
    parameter int SUM_WIDTH       = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    input  logic                       stats_clear,
    output logic                       stat_valid,
    output logic [STAMP_WIDTH-1:0]     stat_last,
    output logic [STAMP_WIDTH-1:0]     stat_min,
    output logic [STAMP_WIDTH-1:0]     stat_max,
    output logic [SUM_WIDTH-1:0]       stat_sum,
    output logic [COUNT_WIDTH-1:0]     stat_count,
    output logic                       stat_overflow
);

    typedef enum logic {
        ST_FIRST,
        ST_BODY
    } state_t;

    state_t                     r_state;

    // Register slice
    logic                       r_s_ready;
    logic                       r_out_valid;
    logic [AXIS_DATA_WIDTH-1:0] r_out_data;
    logic [AXIS_KEEP_WIDTH-1:0] r_out_keep;
    logic                       r_out_last;
    logic                       r_skid_valid;
    logic [AXIS_DATA_WIDTH-1:0] r_skid_data;
    logic [AXIS_KEEP_WIDTH-1:0] r_skid_keep;
    logic                       r_skid_last;

    // Statistics
    logic                       r_stat_valid;
    logic [STAMP_WIDTH-1:0]     r_stat_last;
    logic [STAMP_WIDTH-1:0]     r_stat_min;
    logic [STAMP_WIDTH-1:0]     r_stat_max;
    logic [SUM_WIDTH-1:0]       r_stat_sum;
    logic [COUNT_WIDTH-1:0]     r_stat_count;
    logic                       r_stat_overflow;

    logic                       w_in_fire;
    logic                       w_first_fire;
    logic                       w_out_room;
    logic [AXIS_DATA_WIDTH-1:0] w_in_data;
    logic [STAMP_WIDTH-1:0]     w_stamp;
    logic [STAMP_WIDTH-1:0]     w_base_min;
    logic [STAMP_WIDTH-1:0]     w_base_max;
    logic [SUM_WIDTH-1:0]       w_base_sum;
    logic [COUNT_WIDTH-1:0]     w_base_count;
    logic                       w_base_overflow;
    logic [SUM_WIDTH:0]         w_sum_next;
    logic [COUNT_WIDTH:0]       w_count_next;

    assign w_in_fire    = s_axis_tvalid & r_s_ready;
    assign w_first_fire = w_in_fire & (r_state == ST_FIRST);
    // The output register can take a new beat when empty or draining now.
    assign w_out_room   = m_axis_tready | ~r_out_valid;
    assign w_stamp      = s_axis_tdata[AXIS_DATA_WIDTH-1 -: STAMP_WIDTH];

    // A clear in the same cycle as a sample is applied first, so the sample
    // is folded into freshly cleared statistics.
    assign w_base_min      = stats_clear ? '1 : r_stat_min;
    assign w_base_max      = stats_clear ? '0 : r_stat_max;
    assign w_base_sum      = stats_clear ? '0 : r_stat_sum;
    assign w_base_count    = stats_clear ? '0 : r_stat_count;
    assign w_base_overflow = stats_clear ? 1'b0 : r_stat_overflow;

    // One extra MSB on each adder catches the carry that triggers clamping.
    assign w_sum_next   = {1'b0, w_base_sum}
                        + {{(SUM_WIDTH + 1 - STAMP_WIDTH){1'b0}}, w_stamp};
    assign w_count_next = {1'b0, w_base_count} + {{COUNT_WIDTH{1'b0}}, 1'b1};

    // Beat entering the slice, with the stamp optionally stripped on first beats
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        w_in_data = s_axis_tdata;
`ifdef RX_LATCOL_STAMP_STRIP_EN
        if (r_state == ST_FIRST) begin
            w_in_data[AXIS_DATA_WIDTH-1 -: STAMP_WIDTH] = '0;
        end
`endif
    end

    // Packet framing: tracks whether the next accepted beat opens a packet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FIRST;
        end else if (w_in_fire) begin
            case (r_state)
                ST_FIRST: r_state <= s_axis_tlast ? ST_FIRST : ST_BODY;
                ST_BODY:  r_state <= s_axis_tlast ? ST_FIRST : ST_BODY;
                default:  r_state <= ST_FIRST;
            endcase
        end
    end

    // Slice occupancy and the registered input ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_s_ready    <= 1'b0;
        end else if (r_skid_valid) begin
            // Input is stalled while the skid entry is held; drain it first.
            if (w_out_room) begin
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_s_ready    <= 1'b1;
            end
        end else begin
            r_s_ready <= 1'b1;
            if (w_out_room) begin
                r_out_valid <= w_in_fire;
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_s_ready    <= 1'b0;
            end
        end
    end

    // Slice payload: moves in lock-step with the occupancy flags above
    // NOTE: payload registers carry no reset; the valid flags alone qualify them.
    always_ff @(posedge clk) begin
        if (r_skid_valid) begin
            if (w_out_room) begin
                r_out_data <= r_skid_data;
                r_out_keep <= r_skid_keep;
                r_out_last <= r_skid_last;
            end
        end else if (w_out_room) begin
            if (w_in_fire) begin
                r_out_data <= w_in_data;
                r_out_keep <= s_axis_tkeep;
                r_out_last <= s_axis_tlast;
            end
        end else if (w_in_fire) begin
            r_skid_data <= w_in_data;
            r_skid_keep <= s_axis_tkeep;
            r_skid_last <= s_axis_tlast;
        end
    end

    // Statistics: sample on first-beat acceptance, clear on request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_valid    <= 1'b0;
            r_stat_last     <= '0;
            r_stat_min      <= '1;
            r_stat_max      <= '0;
            r_stat_sum      <= '0;
            r_stat_count    <= '0;
            r_stat_overflow <= 1'b0;
        end else begin
            r_stat_valid <= w_first_fire;
            if (w_first_fire) begin
                r_stat_last     <= w_stamp;
                r_stat_min      <= (w_stamp < w_base_min) ? w_stamp : w_base_min;
                r_stat_max      <= (w_stamp > w_base_max) ? w_stamp : w_base_max;
                r_stat_sum      <= w_sum_next[SUM_WIDTH] ? '1 : w_sum_next[SUM_WIDTH-1:0];
                r_stat_count    <= w_count_next[COUNT_WIDTH] ? '1 : w_count_next[COUNT_WIDTH-1:0];
                r_stat_overflow <= w_base_overflow | w_sum_next[SUM_WIDTH]
                                 | w_count_next[COUNT_WIDTH];
            end else if (stats_clear) begin
                r_stat_last     <= '0;
                r_stat_min      <= '1;
                r_stat_max      <= '0;
                r_stat_sum      <= '0;
                r_stat_count    <= '0;
                r_stat_overflow <= 1'b0;
            end
        end
    end

    assign s_axis_tready = r_s_ready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign stat_valid    = r_stat_valid;
    assign stat_last     = r_stat_last;
    assign stat_min      = r_stat_min;
    assign stat_max      = r_stat_max;
    assign stat_sum      = r_stat_sum;
    assign stat_count    = r_stat_count;
    assign stat_overflow = r_stat_overflow;

endmodule
